// File: rtl/aes_axis_ingress.sv
// AXI-Stream ingress for the AES datapath: command word, then payload packed 4 words per block RAM entry.
// Optional feature INGRESS_ERR_CNT_EN adds err_cnt, a saturating count of packets that ended with an error.
module aes_axis_ingress #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic              blk_we,
  output logic [ADDR_W-1:0] blk_waddr,
  output logic [0:DATA_W-1] blk_wdata,
  output logic [0:31]       aes_cmd,
  output logic [ADDR_W-1:0] blk_cnt,
  output logic              aes_en,
  input  logic              aes_done,
`ifdef INGRESS_ERR_CNT_EN
  output logic [15:0]       err_cnt,
`endif
  output logic              pad_err,
  output logic              ovf_err
);

  localparam logic [ADDR_W-1:0] MAX_BLKS = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {CMD, DATA, START, WAIT} state_t;

  state_t            state;
  logic [1:0]        idx;
  logic [0:DATA_W-1] lanes;
  logic [0:DATA_W-1] lanes_next;
  logic              accept;

`ifdef INGRESS_ERR_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign s_axis_tready = !reset && (state == CMD || state == DATA);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Lanes not yet written stay zero, so a short final block is padded for free.
  always_comb begin
    lanes_next = lanes;
    lanes_next[{idx, 5'd0} +: 32] = s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CMD;
      idx       <= 2'd0;
      lanes     <= '0;
      blk_we    <= 1'b0;
      blk_waddr <= '0;
      blk_wdata <= '0;
      aes_cmd   <= '0;
      blk_cnt   <= '0;
      aes_en    <= 1'b0;
      pad_err   <= 1'b0;
      ovf_err   <= 1'b0;
`ifdef INGRESS_ERR_CNT_EN
      err_cnt   <= 16'd0;
`endif
    end else begin
      blk_we <= 1'b0;
      aes_en <= 1'b0;
      case (state)
        CMD: begin
          if (accept) begin
            aes_cmd <= s_axis_tdata;
            blk_cnt <= '0;
            idx     <= 2'd0;
            lanes   <= '0;
            pad_err <= 1'b0;
            ovf_err <= 1'b0;
            state   <= s_axis_tlast ? START : DATA;
          end
        end
        DATA: begin
          if (accept) begin
            // Once the RAM is full, the rest of the packet is drained and dropped.
            if (blk_cnt == MAX_BLKS) begin
              ovf_err <= 1'b1;
            end else if (idx == 2'd3 || s_axis_tlast) begin
              blk_we    <= 1'b1;
              blk_waddr <= blk_cnt;
              blk_wdata <= lanes_next;
              blk_cnt   <= blk_cnt + 1'b1;
              idx       <= 2'd0;
              lanes     <= '0;
              if (idx != 2'd3) pad_err <= 1'b1;
            end else begin
              lanes <= lanes_next;
              idx   <= idx + 2'd1;
            end
            if (s_axis_tlast) state <= START;
          end
        end
        START: begin
          aes_en <= 1'b1;
          state  <= WAIT;
`ifdef INGRESS_ERR_CNT_EN
          if (pad_err || ovf_err) err_cnt <= sat_inc(err_cnt);
`endif
        end
        WAIT: begin
          if (aes_done) state <= CMD;
        end
        default: state <= CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_axis_ingress.sv
// Bench for aes_axis_ingress: directed and random packets checked against a block-level model.
module tb_aes_axis_ingress;

  localparam int AW   = 2;
  localparam int MAXB = (1 << AW) - 1;

  logic          clk;
  logic          reset;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          blk_we;
  logic [AW-1:0] blk_waddr;
  logic [0:127]  blk_wdata;
  logic [0:31]   aes_cmd;
  logic [AW-1:0] blk_cnt;
  logic          aes_en;
  logic          aes_done;
  logic          pad_err;
  logic          ovf_err;
`ifdef INGRESS_ERR_CNT_EN
  logic [15:0]   err_cnt;
  int            err_exp = 0;
`endif

  int npass  = 0;
  int ntotal = 0;
  int cyc = 0, acc_cnt = 0, last_acc = 0, en_cnt = 0, en_cyc = 0;
  logic [AW-1:0] wa_q[$];
  logic [127:0]  wd_q[$];
  int            wc_q[$];
  logic [31:0]   pay[$];

  aes_axis_ingress #(.ADDR_W(AW), .DATA_W(128)) dut (
    .clk(clk),
    .reset(reset),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .blk_we(blk_we),
    .blk_waddr(blk_waddr),
    .blk_wdata(blk_wdata),
    .aes_cmd(aes_cmd),
    .blk_cnt(blk_cnt),
    .aes_en(aes_en),
    .aes_done(aes_done),
`ifdef INGRESS_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .pad_err(pad_err),
    .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_axis_tvalid && s_axis_tready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= cyc;
    end
  end

  always @(negedge clk) begin
    if (blk_we) begin
      wa_q.push_back(blk_waddr);
      wd_q.push_back(blk_wdata);
      wc_q.push_back(cyc);
    end
    if (aes_en) begin
      en_cnt <= en_cnt + 1;
      en_cyc <= cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tready"}, 128'(s_axis_tready), 128'(0));
    chk({tag, "_we"},     128'(blk_we),        128'(0));
    chk({tag, "_waddr"},  128'(blk_waddr),     128'(0));
    chk({tag, "_wdata"},  128'(blk_wdata),     128'(0));
    chk({tag, "_cmd"},    128'(aes_cmd),       128'(0));
    chk({tag, "_blkcnt"}, 128'(blk_cnt),       128'(0));
    chk({tag, "_en"},     128'(aes_en),        128'(0));
    chk({tag, "_pad"},    128'(pad_err),       128'(0));
    chk({tag, "_ovf"},    128'(ovf_err),       128'(0));
`ifdef INGRESS_ERR_CNT_EN
    chk({tag, "_errcnt"}, 128'(err_cnt),       128'(0));
`endif
  endtask

  // Called at a negedge; returns at the negedge after the word was taken.
  task automatic send_word(input logic [31:0] d, input logic last);
    int guard;
    guard = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    #1;
    while (!s_axis_tready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("accept_ready", 128'(s_axis_tready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic run_packet(input string name, input logic [31:0] cmd, input int gap);
    int n, nraw, nexp, base_acc, base_en, guard, lastw;
    logic exp_ovf, exp_pad;
    logic [127:0] blk;
    n       = pay.size();
    nraw    = (n + 3) / 4;
    nexp    = (nraw > MAXB) ? MAXB : nraw;
    exp_ovf = (n > 4 * MAXB);
    exp_pad = !exp_ovf && (n % 4 != 0);
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    base_acc = acc_cnt;
    base_en  = en_cnt;

    send_word(cmd, n == 0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap)) @(negedge clk);
      send_word(pay[i], i == n - 1);
    end

    // Keep offering a word while the controller is busy; none may be taken.
    s_axis_tdata  = 32'hDEAD_BEEF;
    s_axis_tvalid = 1'b1;
    guard = 0;
    #2;
    while (en_cnt == base_en && guard < 10) begin
      @(negedge clk);
      #2;
      guard++;
    end
    chk({name, "_en_seen"}, 128'(en_cnt - base_en), 128'(1));
    chk({name, "_en_lat"},  128'(en_cyc - last_acc), 128'(2));
    repeat (3) @(negedge clk);
    #2;
    chk({name, "_en_once"},    128'(en_cnt - base_en),   128'(1));
    chk({name, "_wait_ready"}, 128'(s_axis_tready),      128'(0));
    chk({name, "_accepted"},   128'(acc_cnt - base_acc), 128'(n + 1));
    chk({name, "_nwrites"},    128'(wa_q.size()),        128'(nexp));
    for (int b = 0; b < nexp && b < wa_q.size(); b++) begin
      blk = '0;
      for (int j = 0; j < 4; j++)
        blk = {blk[95:0], (4 * b + j < n) ? pay[4 * b + j] : 32'h0};
      chk({name, "_waddr"}, 128'(wa_q[b]), 128'(b));
      chk({name, "_wdata"}, wd_q[b], blk);
    end
    if (!exp_ovf && nexp > 0 && wc_q.size() > 0) begin
      lastw = wc_q[wc_q.size() - 1];
      chk({name, "_wr_lat"}, 128'(lastw - last_acc), 128'(1));
    end
    chk({name, "_blkcnt"}, 128'(blk_cnt), 128'(nexp));
    chk({name, "_pad"},    128'(pad_err), 128'(exp_pad));
    chk({name, "_ovf"},    128'(ovf_err), 128'(exp_ovf));
    chk({name, "_cmd"},    128'(aes_cmd), 128'(cmd));
`ifdef INGRESS_ERR_CNT_EN
    if (exp_pad || exp_ovf) err_exp++;
    chk({name, "_errcnt"}, 128'(err_cnt), 128'(err_exp));
`endif

    s_axis_tvalid = 1'b0;
    aes_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    aes_done = 1'b0;
    #1;
    chk({name, "_done_ready"}, 128'(s_axis_tready), 128'(1));
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    aes_done      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    pay.delete();
    for (int i = 0; i < 8; i++) pay.push_back(32'(i));
    run_packet("encrypt", 32'h0000_0001, 0);

    pay.delete();
    for (int i = 0; i < 6; i++) pay.push_back($urandom);
    run_packet("setkey_pad", 32'h0000_0003, 1);

    pay.delete();
    run_packet("cmd_only", 32'h0000_0002, 0);

    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back($urandom);
    run_packet("overflow", 32'h0000_0001, 1);

    for (int p = 0; p < 8; p++) begin
      pay.delete();
      for (int i = 0; i < $urandom_range(0, 16); i++) pay.push_back($urandom);
      run_packet($sformatf("rand%0d", p), $urandom, 2);
    end

    // Abort a packet part-way through with reset.
    send_word(32'h0000_0005, 1'b0);
    send_word(32'hA1A1_A1A1, 1'b0);
    send_word(32'hA2A2_A2A2, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_zero("midrst");
`ifdef INGRESS_ERR_CNT_EN
    err_exp = 0;
`endif
    reset = 1'b0;
    @(negedge clk);

    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back($urandom);
    run_packet("post_rst", 32'h0000_0007, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
